// File: rtl/cia_interrupt.sv
// CIA interrupt control register: latches timer/TOD/serial/FLAG events, applies the mask and drives IRQ.
// Define CIA_OLD_IRQ_DELAY_EN for old-6526 timing (one extra PHI2 stage before irq_n falls).
module cia_interrupt (
  input  logic       clk,
  input  logic       res,
  input  logic       phi2_dn,
  input  logic       icr_w,
  input  logic       icr_r,
  input  logic [7:0] data,
  input  logic       ta_int,
  input  logic       tb_int,
  input  logic       alarm,
  input  logic       sp_int,
  input  logic       flag_n,
  output logic [7:0] icr,
  output logic       irq_n
);

  logic [4:0] flags_q, flags_d;
  logic [4:0] mask_q, mask_d;
  logic [4:0] ev;
  logic       ir_q, ir_d;
  logic       irq_q, irq_d;
  logic       flag_n_prev_q;
  logic       pending;
  logic       new_masked;
  logic       data_unused;

  assign data_unused = &{1'b0, data[6:5]};

`ifdef CIA_OLD_IRQ_DELAY_EN
  logic irq_dly_q, irq_dly_d;
`endif

  always_comb begin
    ev      = {~flag_n & flag_n_prev_q, sp_int, alarm, tb_int, ta_int};
    // A read clears the latched flags, but an event in the same cycle survives.
    flags_d = (icr_r ? 5'b0 : flags_q) | ev;
    mask_d  = mask_q;
    if (icr_w) begin
      mask_d = data[7] ? (mask_q | data[4:0]) : (mask_q & ~data[4:0]);
    end
    pending    = |(flags_q & mask_q);
    new_masked = |(ev & mask_d);
    ir_d       = (|(flags_d & mask_d)) | (ir_q & ~icr_r);
`ifdef CIA_OLD_IRQ_DELAY_EN
    // Extra stage only on the set path; deassertion still follows pending directly.
    irq_dly_d = icr_r ? new_masked : pending;
    irq_d     = icr_r ? 1'b0 : (irq_dly_q & pending);
`else
    irq_d     = icr_r ? new_masked : pending;
`endif
  end

  always_ff @(posedge clk) begin
    if (res) begin
      flags_q       <= '0;
      mask_q        <= '0;
      ir_q          <= 1'b0;
      irq_q         <= 1'b0;
      flag_n_prev_q <= 1'b1;
`ifdef CIA_OLD_IRQ_DELAY_EN
      irq_dly_q     <= 1'b0;
`endif
    end else if (phi2_dn) begin
      flags_q       <= flags_d;
      mask_q        <= mask_d;
      ir_q          <= ir_d;
      irq_q         <= irq_d;
      flag_n_prev_q <= flag_n;
`ifdef CIA_OLD_IRQ_DELAY_EN
      irq_dly_q     <= irq_dly_d;
`endif
    end
  end

  assign icr   = {ir_q, 2'b00, flags_q};
  assign irq_n = ~irq_q;

endmodule

// File: tb/tb_cia_interrupt.sv
// Directed bench for cia_interrupt; one PHI2 tick is two clk periods with phi2_dn on the second.
module tb_cia_interrupt;

`ifdef CIA_OLD_IRQ_DELAY_EN
  localparam bit OLD = 1'b1;
`else
  localparam bit OLD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       phi2_dn = 1'b0;
  logic       icr_w = 1'b0;
  logic       icr_r = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ta_int = 1'b0;
  logic       tb_int = 1'b0;
  logic       alarm = 1'b0;
  logic       sp_int = 1'b0;
  logic       flag_n = 1'b1;
  logic [7:0] icr;
  logic       irq_n;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cia_interrupt dut (
    .clk     (clk),
    .res     (res),
    .phi2_dn (phi2_dn),
    .icr_w   (icr_w),
    .icr_r   (icr_r),
    .data    (data),
    .ta_int  (ta_int),
    .tb_int  (tb_int),
    .alarm   (alarm),
    .sp_int  (sp_int),
    .flag_n  (flag_n),
    .icr     (icr),
    .irq_n   (irq_n)
  );

  // One PHI2 cycle: a non-strobe clk, then the strobe clk; one-cycle inputs drop afterwards.
  task automatic tick();
    @(negedge clk);
    phi2_dn = 1'b1;
    @(negedge clk);
    phi2_dn = 1'b0;
    res    = 1'b0;
    icr_w  = 1'b0;
    icr_r  = 1'b0;
    ta_int = 1'b0;
    tb_int = 1'b0;
    alarm  = 1'b0;
    sp_int = 1'b0;
  endtask

  task automatic wr(input logic [7:0] v);
    icr_w = 1'b1;
    data  = v;
    tick();
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-18s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
    $display("check %-18s observed=%b expected=%b", tag, obs, exp);
  endtask

  initial begin
    // Reset state
    tick();
    chk8("rst_icr", icr, 8'h00);
    chk1("rst_irq", irq_n, 1'b1);

    // TA enabled, single underflow
    wr(8'h81);
    chk8("wr81_icr", icr, 8'h00);
    repeat (3) tick();
    ta_int = 1'b1; tick();
    chk8("ta_icr", icr, 8'h81);
    chk1("ta_irq_evt", irq_n, 1'b1);
    if (OLD) begin
      tick();
      chk1("ta_irq_old_mid", irq_n, 1'b1);
    end
    tick();
    chk1("ta_irq_low", irq_n, 1'b0);
    chk8("ta_preread", icr, 8'h81);
    icr_r = 1'b1; tick();
    chk8("ta_postread", icr, 8'h00);
    chk1("ta_read_irq", irq_n, 1'b1);

    // Masked-off TB, then enable mask for the pending flag
    wr(8'h01);
    tb_int = 1'b1; tick();
    chk8("tb_nomask_icr", icr, 8'h02);
    tick();
    chk1("tb_nomask_irq", irq_n, 1'b1);
    wr(8'h82);
    chk8("tb_en_icr", icr, 8'h82);
    chk1("tb_en_irq", irq_n, 1'b1);
    if (OLD) tick();
    tick();
    chk1("tb_en_irq_low", irq_n, 1'b0);
    chk8("tb_preread", icr, 8'h82);
    icr_r = 1'b1; tick();
    chk8("tb_postread", icr, 8'h00);
    chk1("tb_read_irq", irq_n, 1'b1);
    icr_r = 1'b1; tick();
    chk8("tb_read2", icr, 8'h00);

    // Read colliding with an alarm event
    wr(8'h84);
    alarm = 1'b1; tick();
    chk8("al_icr", icr, 8'h84);
    if (OLD) tick();
    tick();
    chk1("al_irq_low", irq_n, 1'b0);
    chk8("al_preread", icr, 8'h84);
    icr_r = 1'b1; alarm = 1'b1; tick();
    chk8("al_collide_icr", icr, 8'h84);
    tick();
    chk1("al_collide_irq", irq_n, 1'b0);
    icr_r = 1'b1; tick();
    chk8("al_clear_icr", icr, 8'h00);
    chk1("al_clear_irq", irq_n, 1'b1);

    // FLAG held low: one event on the falling edge only
    wr(8'h90);
    flag_n = 1'b0; tick();
    chk8("flg_icr", icr, 8'h90);
    icr_r = 1'b1; tick();
    chk8("flg_read", icr, 8'h00);
    repeat (3) tick();
    chk8("flg_held", icr, 8'h00);
    chk1("flg_held_irq", irq_n, 1'b1);
    flag_n = 1'b1; tick();
    chk8("flg_rise", icr, 8'h00);

    // Clearing the mask of the only pending source
    wr(8'h81);
    ta_int = 1'b1; tick();
    chk8("mclr_icr", icr, 8'h81);
    if (OLD) tick();
    tick();
    chk1("mclr_irq_low", irq_n, 1'b0);
    wr(8'h01);
    tick();
    chk1("mclr_irq_rel", irq_n, 1'b1);
    chk8("mclr_icr_kept", icr, 8'h81);
    icr_r = 1'b1; tick();
    chk8("mclr_read", icr, 8'h00);

    // All sources at once, then reset mid-operation
    wr(8'h9F);
    ta_int = 1'b1; tb_int = 1'b1; alarm = 1'b1; sp_int = 1'b1; flag_n = 1'b0; tick();
    chk8("all_icr", icr, 8'h9F);
    if (OLD) tick();
    tick();
    chk1("all_irq_low", irq_n, 1'b0);
    res = 1'b1; flag_n = 1'b1; tick();
    chk8("res_icr", icr, 8'h00);
    chk1("res_irq", irq_n, 1'b1);
    ta_int = 1'b1; tick();
    chk8("res_ta_icr", icr, 8'h01);
    repeat (2) tick();
    chk1("res_ta_irq", irq_n, 1'b1);

    // Events outside the phi2_dn strobe are ignored
    icr_r = 1'b1; tick();
    chk8("off_read", icr, 8'h00);
    ta_int = 1'b1;
    @(negedge clk);
    ta_int = 1'b0;
    tick();
    chk8("off_phase_ta", icr, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
